// File: rtl/note_source_arbiter_pkg.sv
// Shared audio definitions: divider width, silence value, arbiter states
// and the default 10 ms switch gap at a 100 MHz clock.
package note_source_arbiter_pkg;

    localparam int DIV_W_DEF       = 22;
    localparam int GAP_10MS_100MHZ = 1000000;

    localparam logic [DIV_W_DEF-1:0] SILENT_DIV = {DIV_W_DEF{1'b0}};

    typedef enum logic [0:0] {
        PLAY = 1'b0,
        GAP  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/note_source_arbiter_gap.sv
// Loadable down-counter with a registered zero flag; also suits rest timing
// in the note sequencers.
module gap_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;
    logic             zero_r;

    // Counter and zero flag; the flag is precomputed so it matches count_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            zero_r  <= 1'b1;
        end else if (load) begin
            count_r <= load_val;
            zero_r  <= (load_val == {CNT_W{1'b0}});
        end else if (dec && !zero_r) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
            zero_r  <= (count_r == {{(CNT_W-1){1'b0}}, 1'b1});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/note_source_arbiter.sv
// Registered selector routing one of NUM_SRC note-divider pairs to the
// buzzer, with a silence gap inserted on every source change.
module note_source_arbiter
    import note_source_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int SEL_W      = 2,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int GAP_CYCLES = GAP_10MS_100MHZ,
    parameter int CNT_W      = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     mute,
    input  logic [NUM_SRC*DIV_W-1:0] src_div_right,
    input  logic [NUM_SRC*DIV_W-1:0] src_div_left,
    output logic [DIV_W-1:0]         note_div_right,
    output logic [DIV_W-1:0]         note_div_left,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     busy
);

    localparam bit               GAP_EN   = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] GAP_LOAD = GAP_EN ? CNT_W'(GAP_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [DIV_W-1:0] SILENT   = DIV_W'(SILENT_DIV);

    arb_state_e       state_r;
    logic [SEL_W-1:0] active_sel_r;
    logic [SEL_W-1:0] pending_sel_r;
    logic [DIV_W-1:0] div_right_r;
    logic [DIV_W-1:0] div_left_r;
    logic             busy_r;

    logic [DIV_W-1:0] src_right_s;
    logic [DIV_W-1:0] src_left_s;
    logic [DIV_W-1:0] play_right_s;
    logic [DIV_W-1:0] play_left_s;
    logic             sel_change_s;
    logic             restart_s;
    logic             timer_load_s;
    logic             timer_dec_s;
    logic             timer_zero_s;

    function automatic logic is_silent(input logic [SEL_W-1:0] idx);
        return (idx == {SEL_W{1'b0}}) || (int'(idx) >= NUM_SRC);
    endfunction

    // Extract the active pair; index 0 and out-of-range indices never match.
    always_comb begin
        src_right_s = SILENT;
        src_left_s  = SILENT;
        for (int i = 1; i < NUM_SRC; i++) begin
            src_right_s = (active_sel_r == SEL_W'(i)) ? src_div_right[i*DIV_W +: DIV_W] : src_right_s;
            src_left_s  = (active_sel_r == SEL_W'(i)) ? src_div_left[i*DIV_W +: DIV_W]  : src_left_s;
        end
        play_right_s = (mute || is_silent(active_sel_r)) ? SILENT : src_right_s;
        play_left_s  = (mute || is_silent(active_sel_r)) ? SILENT : src_left_s;
    end

    assign sel_change_s = (sel != active_sel_r);
    assign restart_s    = (sel != pending_sel_r);

    // Timer control: load on gap entry or restart, count down while gapping.
    always_comb begin
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        case (state_r)
            PLAY: begin
                timer_load_s = sel_change_s && GAP_EN;
                timer_dec_s  = 1'b0;
            end
            GAP: begin
                timer_load_s = restart_s;
                timer_dec_s  = 1'b1;
            end
            default: begin
                timer_load_s = 1'b0;
                timer_dec_s  = 1'b0;
            end
        endcase
    end

    gap_timer #(
        .CNT_W (CNT_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (GAP_LOAD),
        .dec      (timer_dec_s),
        .zero     (timer_zero_s)
    );

    // Arbiter FSM with registered outputs; a restart takes priority over completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= PLAY;
            active_sel_r  <= {SEL_W{1'b0}};
            pending_sel_r <= {SEL_W{1'b0}};
            div_right_r   <= SILENT;
            div_left_r    <= SILENT;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                PLAY: begin
                    if (sel_change_s && GAP_EN) begin
                        state_r       <= GAP;
                        pending_sel_r <= sel;
                        div_right_r   <= SILENT;
                        div_left_r    <= SILENT;
                        busy_r        <= 1'b1;
                    end else begin
                        if (sel_change_s) begin
                            active_sel_r <= sel;
                        end
                        div_right_r <= play_right_s;
                        div_left_r  <= play_left_s;
                        busy_r      <= 1'b0;
                    end
                end
                GAP: begin
                    div_right_r <= SILENT;
                    div_left_r  <= SILENT;
                    if (restart_s) begin
                        pending_sel_r <= sel;
                    end else if (timer_zero_s) begin
                        state_r      <= PLAY;
                        active_sel_r <= pending_sel_r;
                        busy_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= PLAY;
                    div_right_r <= SILENT;
                    div_left_r  <= SILENT;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign note_div_right = div_right_r;
    assign note_div_left  = div_left_r;
    assign active_sel     = active_sel_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_note_source_arbiter.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge
// monitor compares every entry due on that cycle.
module tb_note_source_arbiter;

    localparam int DW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 4 sources, 4-cycle gap
    logic            rst_a_n;
    logic [1:0]      sel_a;
    logic            mute_a;
    logic [4*DW-1:0] src_r_a, src_l_a;
    logic [DW-1:0]   out_r_a, out_l_a;
    logic [1:0]      act_a;
    logic            busy_a;

    // Instance B: 3 sources, no gap
    logic            rst_b_n;
    logic [1:0]      sel_b;
    logic            mute_b;
    logic [3*DW-1:0] src_r_b, src_l_b;
    logic [DW-1:0]   out_r_b, out_l_b;
    logic [1:0]      act_b;
    logic            busy_b;

    note_source_arbiter #(
        .NUM_SRC(4), .SEL_W(2), .DIV_W(DW), .GAP_CYCLES(4), .CNT_W(20)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .sel(sel_a), .mute(mute_a),
        .src_div_right(src_r_a), .src_div_left(src_l_a),
        .note_div_right(out_r_a), .note_div_left(out_l_a),
        .active_sel(act_a), .busy(busy_a)
    );

    note_source_arbiter #(
        .NUM_SRC(3), .SEL_W(2), .DIV_W(DW), .GAP_CYCLES(0), .CNT_W(20)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .sel(sel_b), .mute(mute_b),
        .src_div_right(src_r_b), .src_div_left(src_l_b),
        .note_div_right(out_r_b), .note_div_left(out_l_b),
        .active_sel(act_b), .busy(busy_b)
    );

    typedef struct {
        int          cyc;
        int          inst;
        logic [DW-1:0] r;
        logic [DW-1:0] l;
        logic [1:0]  a;
        logic        b;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_exp(input int c, input int inst, input logic [DW-1:0] r,
                            input logic [DW-1:0] l, input logic [1:0] a,
                            input logic b, input string nm);
        exp_t e;
        e.cyc = c; e.inst = inst; e.r = r; e.l = l; e.a = a; e.b = b; e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic push_span(input int c0, input int c1, input int inst,
                             input logic [DW-1:0] r, input logic [DW-1:0] l,
                             input logic [1:0] a, input logic b, input string nm);
        for (int c = c0; c <= c1; c++) push_exp(c, inst, r, l, a, b, nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: pop and compare every expectation due at or before this cycle.
    logic [DW-1:0] mon_r, mon_l;
    logic [1:0]    mon_a;
    logic          mon_b;
    int            mon_i;
    always @(negedge clk) begin
        mon_i = 0;
        while (mon_i < sb_q.size()) begin
            if (sb_q[mon_i].cyc <= cyc) begin
                if (sb_q[mon_i].inst == 0) begin
                    mon_r = out_r_a; mon_l = out_l_a; mon_a = act_a; mon_b = busy_a;
                end else begin
                    mon_r = out_r_b; mon_l = out_l_b; mon_a = act_b; mon_b = busy_b;
                end
                n_tests++;
                if (sb_q[mon_i].cyc != cyc || mon_r !== sb_q[mon_i].r || mon_l !== sb_q[mon_i].l ||
                    mon_a !== sb_q[mon_i].a || mon_b !== sb_q[mon_i].b) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d (due %0d): got r=%0d l=%0d sel=%0d busy=%0d, want r=%0d l=%0d sel=%0d busy=%0d",
                             sb_q[mon_i].nm, cyc, sb_q[mon_i].cyc, mon_r, mon_l, mon_a, mon_b,
                             sb_q[mon_i].r, sb_q[mon_i].l, sb_q[mon_i].a, sb_q[mon_i].b);
                end
                sb_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    int e0, t, m, p, b;

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        sel_a = 2'd0; sel_b = 2'd0; mute_a = 1'b0; mute_b = 1'b0;
        src_r_a = {22'd120000, 22'd100000, 22'd191571, 22'd12345};
        src_l_a = {22'd120001, 22'd100001, 22'd191571, 22'd23456};
        src_r_b = {22'd50000, 22'd191571, 22'd11111};
        src_l_b = {22'd50001, 22'd95786, 22'd11111};

        step(2);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        e0 = cyc;
        push_span(e0, e0 + 19, 0, 22'd0, 22'd0, 2'd0, 1'b0, "reset_silence");
        push_span(e0, e0 + 3, 1, 22'd0, 22'd0, 2'd0, 1'b0, "b_reset");
        step(19);

        // Clean switch 0 -> 1
        t = cyc;
        sel_a = 2'd1;
        push_span(t + 1, t + 4, 0, 22'd0, 22'd0, 2'd0, 1'b1, "gap_busy");
        push_exp(t + 5, 0, 22'd0, 22'd0, 2'd1, 1'b0, "gap_done");
        push_exp(t + 6, 0, 22'd191571, 22'd191571, 2'd1, 1'b0, "switch_src1");
        step(6);

        // Restart: 1 -> 2, then 2 -> 3 two cycles into the gap
        t = cyc;
        sel_a = 2'd2;
        push_span(t + 1, t + 6, 0, 22'd0, 22'd0, 2'd1, 1'b1, "restart_gap");
        push_exp(t + 7, 0, 22'd0, 22'd0, 2'd3, 1'b0, "restart_done");
        push_exp(t + 8, 0, 22'd120000, 22'd120001, 2'd3, 1'b0, "switch_src3");
        step(2);
        sel_a = 2'd3;
        step(6);

        // Mute for 3 cycles, then passthrough of a divider change
        m = cyc;
        mute_a = 1'b1;
        push_span(m + 1, m + 3, 0, 22'd0, 22'd0, 2'd3, 1'b0, "mute");
        push_exp(m + 4, 0, 22'd120000, 22'd120001, 2'd3, 1'b0, "unmute");
        step(3);
        mute_a = 1'b0;
        step(1);
        src_r_a[3*DW +: DW] = 22'd143172;
        push_exp(m + 5, 0, 22'd143172, 22'd120001, 2'd3, 1'b0, "passthru");
        step(1);

        // Async reset mid-gap with counter at 2
        p = cyc;
        sel_a = 2'd1;
        push_exp(p + 1, 0, 22'd0, 22'd0, 2'd3, 1'b1, "pre_rst_gap");
        step(2);
        rst_a_n = 1'b0;
        sel_a = 2'd0;
        push_exp(p + 2, 0, 22'd0, 22'd0, 2'd0, 1'b0, "async_rst");
        step(2);
        rst_a_n = 1'b1;
        push_span(p + 4, p + 12, 0, 22'd0, 22'd0, 2'd0, 1'b0, "no_pending");
        step(8);

        // Zero gap, out-of-range source
        b = cyc;
        sel_b = 2'd3;
        push_span(b + 1, b + 4, 1, 22'd0, 22'd0, 2'd3, 1'b0, "b_oor");
        step(4);
        sel_b = 2'd1;
        push_exp(b + 5, 1, 22'd0, 22'd0, 2'd1, 1'b0, "b_zero_gap");
        push_exp(b + 6, 1, 22'd191571, 22'd95786, 2'd1, 1'b0, "b_src1");
        step(3);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: got %0d unchecked expectations, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
